// File: rtl/mul_div_writeback_unit.sv
// Iterative unsigned multiply/divide unit with a single register-file write-back per operation.
// One operand bit is processed per clock. One operation is in flight at a time.
module mul_div_writeback_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] AData,
  input  logic [WIDTH-1:0] BData,
  input  logic [AW-1:0]    DestAddr,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] WriteRegData,
  output logic [AW-1:0]    WriteRegAddr,
  output logic             WRF
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sel_hi_q, sel_hi_d;
  logic [AW-1:0]      dest_q, dest_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, wrf_q, wrf_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [AW-1:0]      waddr_q, waddr_d;

  logic [WIDTH:0]     mul_sum_c, div_shift_c, div_trial_c;
  logic [2*WIDTH-1:0] mul_step_c, div_step_c;
  logic               last_c;

  // Datapath steps: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_step_c  = {mul_sum_c, acc_q[WIDTH-1:1]};
    div_shift_c = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial_c = div_shift_c - {1'b0, b_q};
    div_step_c  = div_trial_c[WIDTH]
                ? {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                : {div_trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    last_c      = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_hi_d = sel_hi_q;
    dest_d   = dest_q;
    cnt_d    = cnt_q;
    dbz_d    = dbz_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    wrf_d    = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          a_d      = AData;
          b_d      = BData;
          sel_hi_d = Op[0];
          dest_d   = DestAddr;
          cnt_d    = '0;
          dbz_d    = Op[1] && (BData == '0);
          acc_d    = {{WIDTH{1'b0}}, (Op[1] ? AData : BData)};
          state_d  = Op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        acc_d = mul_step_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) begin
          state_d = WB;
          wrf_d   = 1'b1;
          done_d  = 1'b1;
          waddr_d = dest_q;
          wdata_d = sel_hi_q ? mul_step_c[2*WIDTH-1:WIDTH] : mul_step_c[WIDTH-1:0];
        end
      end
      DIV: begin
        // A zero divisor skips the iterations and writes the saturated results.
        if (b_q == '0) begin
          state_d = WB;
          wrf_d   = 1'b1;
          done_d  = 1'b1;
          waddr_d = dest_q;
          wdata_d = sel_hi_q ? a_q : {WIDTH{1'b1}};
        end else begin
          acc_d = div_step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            state_d = WB;
            wrf_d   = 1'b1;
            done_d  = 1'b1;
            waddr_d = dest_q;
            wdata_d = sel_hi_q ? div_step_c[2*WIDTH-1:WIDTH] : div_step_c[WIDTH-1:0];
          end
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_hi_q <= 1'b0;
      dest_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      wrf_q    <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_hi_q <= sel_hi_d;
      dest_q   <= dest_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      wrf_q    <= wrf_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
    end
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign DivByZero    = dbz_q;
  assign WriteRegData = wdata_q;
  assign WriteRegAddr = waddr_q;
  assign WRF          = wrf_q;

endmodule

// File: tb/tb_mul_div_writeback_unit.sv
// Self-checking bench for mul_div_writeback_unit: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_writeback_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] AData, BData;
  logic [4:0]  DestAddr;
  logic        Busy, Done, DivByZero, WRF;
  logic [31:0] WriteRegData;
  logic [4:0]  WriteRegAddr;

  int tests = 0;
  int fails = 0;

  mul_div_writeback_unit dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .AData(AData), .BData(BData),
    .DestAddr(DestAddr), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .WriteRegData(WriteRegData), .WriteRegAddr(WriteRegAddr), .WRF(WRF)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // One operation: accept, scramble inputs, wait bounded for WRF, check result and pulse shape.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest, input bit poke);
    int          n;
    bit          dz;
    logic [31:0] exp;
    exp = ref_result(op, a, b);
    dz  = op[1] && (b == 0);
    @(negedge Clk);
    Start = 1'b1; Op = op; AData = a; BData = b; DestAddr = dest;
    @(posedge Clk); #1;
    Start = 1'b0; Op = 2'($urandom); AData = $urandom; BData = $urandom; DestAddr = 5'($urandom);
    check("busy_after_accept", Busy, 1);
    check("dbz_after_accept", DivByZero, dz);
    n = 0;
    while (!WRF && n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (poke && n == 5) begin
        Start = 1'b1; Op = 2'b00; AData = 32'd3; BData = 32'd5; DestAddr = 5'd17;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    check("latency", 64'(n), dz ? 64'd1 : 64'd32);
    check("wb_data", WriteRegData, exp);
    check("wb_addr", WriteRegAddr, dest);
    check("wb_done", Done, 1);
    check("wb_busy", Busy, 1);
    check("wb_dbz", DivByZero, dz);
    @(posedge Clk); #1;
    check("wrf_pulse", WRF, 0);
    check("done_pulse", Done, 0);
    check("busy_idle", Busy, 0);
    check("data_hold", WriteRegData, exp);
    check("addr_hold", WriteRegAddr, dest);
    if (poke) begin
      n = 0;
      repeat (40) begin
        @(posedge Clk); #1;
        if (WRF || Busy) n++;
      end
      check("poke_no_extra_op", 64'(n), 0);
    end
  endtask

  initial begin
    int          stamp [3];
    int          nwrf, cyc;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    Rst = 1'b1; Start = 1'b0; Op = '0; AData = '0; BData = '0; DestAddr = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_wrf", WRF, 0);
    check("rst_dbz", DivByZero, 0);
    check("rst_data", WriteRegData, 0);
    check("rst_addr", WriteRegAddr, 0);
    @(negedge Clk); Rst = 1'b0;

    // Directed cases
    do_op(2'b00, 32'd7, 32'd6, 5'd3, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0);
    do_op(2'b10, 32'd100, 32'd7, 5'd6, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 5'd7, 1'b0);
    do_op(2'b10, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    do_op(2'b10, 32'd5, 32'd0, 5'd9, 1'b0);
    do_op(2'b11, 32'd5, 32'd0, 5'd9, 1'b0);
    do_op(2'b00, 32'd2, 32'd3, 5'd1, 1'b0);
    do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b1);

    // Start held high: back-to-back ops every 34 cycles
    stamp = '{0, 0, 0};
    @(negedge Clk);
    Start = 1'b1; Op = 2'b01; AData = 32'hDEAD_BEEF; BData = 32'h0BAD_F00D; DestAddr = 5'd21;
    nwrf = 0; cyc = 0;
    while (nwrf < 3 && cyc < 150) begin
      @(posedge Clk); #1;
      cyc++;
      if (WRF) begin
        stamp[nwrf] = cyc;
        check("b2b_data", WriteRegData, ref_result(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D));
        nwrf++;
      end
    end
    @(negedge Clk); Start = 1'b0;
    check("b2b_count", 64'(nwrf), 3);
    check("b2b_period1", 64'(stamp[1] - stamp[0]), 34);
    check("b2b_period2", 64'(stamp[2] - stamp[1]), 34);
    cyc = 0;
    while (Busy && cyc < 50) begin @(posedge Clk); #1; cyc++; end
    check("b2b_drain", Busy, 0);

    // Asynchronous reset in the middle of a divide
    @(negedge Clk);
    Start = 1'b1; Op = 2'b10; AData = 32'd1000; BData = 32'd3; DestAddr = 5'd11;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (10) @(posedge Clk);
    #3 Rst = 1'b1;
    #1;
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_wrf", WRF, 0);
    check("arst_dbz", DivByZero, 0);
    check("arst_data", WriteRegData, 0);
    check("arst_addr", WriteRegAddr, 0);
    @(negedge Clk); Rst = 1'b0;
    nwrf = 0;
    repeat (40) begin @(posedge Clk); #1; if (WRF || Busy) nwrf++; end
    check("arst_no_wrf", 64'(nwrf), 0);
    do_op(2'b11, 32'd1000, 32'd3, 5'd11, 1'b0);

    // Random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      do_op(rop, ra, rb, 5'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
